mem_arbiter: RTL and testbench

- Shares the single-port 16-bit unified memory between two requesters: port 0 is the Core; port 1 is a secondary master such as the display/glyph fetcher or an I/O DMA.
- Sits between the requesters and the block RAM, and serialises their accesses with a 2-way round-robin policy.
- Presents a req/ack handshake on each port, plus a read-data-valid strobe for reads.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter_rr_pick2.sv | 39 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    localparam int DEFAULT_ADDR_W = 24;
    localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus bundle for mem_arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [15:0]       conflict_count;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rvalid, p1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output conflict_count
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rvalid, p1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  conflict_count
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the port that did not win last time wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Grant decision from the current request vector and previous winner
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = PORT_CORE;
        case (req)
            2'b00: begin
                grant_valid = 1'b0;
                grant_idx   = PORT_CORE;
            end
            2'b01: begin
                grant_valid = 1'b1;
                grant_idx   = PORT_CORE;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_idx   = PORT_AUX;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_idx   = ~last_grant;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = PORT_CORE;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto one single-port memory, one access at a time.
// Optional contention counter enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

    arb_state_e        state_r, state_s;
    logic              last_grant_r, last_grant_s;
    logic              gnt_idx_r, gnt_idx_s;
    logic [1:0]        lat_cnt_r, lat_cnt_s;
    logic [1:0]        ack_r, ack_s;
    logic [1:0]        rvalid_r, rvalid_s;
    logic              mem_en_r, mem_en_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              pick_valid_s;
    logic              pick_idx_s;

    rr_pick2 u_pick (
        .req         ({bus.p1_req, bus.p0_req}),
        .last_grant  (last_grant_r),
        .grant_valid (pick_valid_s),
        .grant_idx   (pick_idx_s)
    );

    // Next-state and next-output decode; ack and rvalid are precomputed one cycle early
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        gnt_idx_s    = gnt_idx_r;
        lat_cnt_s    = lat_cnt_r;
        ack_s        = 2'b00;
        rvalid_s     = 2'b00;
        mem_en_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s           = ISSUE;
                    gnt_idx_s         = pick_idx_s;
                    last_grant_s      = pick_idx_s;
                    ack_s[pick_idx_s] = 1'b1;
                    mem_en_s          = 1'b1;
                    mem_we_s          = pick_idx_s ? bus.p1_we    : bus.p0_we;
                    mem_addr_s        = pick_idx_s ? bus.p1_addr  : bus.p0_addr;
                    mem_wdata_s       = pick_idx_s ? bus.p1_wdata : bus.p0_wdata;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_we_r) begin
                    state_s = IDLE;
                end else begin
                    state_s             = WAIT;
                    lat_cnt_s           = LAT_INIT;
                    rvalid_s[gnt_idx_r] = (LAT_INIT == 2'd0);
                end
            end
            WAIT: begin
                if (lat_cnt_r == 2'd0) begin
                    state_s = IDLE;
                end else begin
                    lat_cnt_s           = lat_cnt_r - 2'd1;
                    rvalid_s[gnt_idx_r] = (lat_cnt_r == 2'd1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= PORT_AUX;
            gnt_idx_r    <= PORT_CORE;
            lat_cnt_r    <= 2'd0;
            ack_r        <= 2'b00;
            rvalid_r     <= 2'b00;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            gnt_idx_r    <= gnt_idx_s;
            lat_cnt_r    <= lat_cnt_s;
            ack_r        <= ack_s;
            rvalid_r     <= rvalid_s;
            mem_en_r     <= mem_en_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
        end
    end

    assign bus.p0_ack    = ack_r[PORT_CORE];
    assign bus.p1_ack    = ack_r[PORT_AUX];
    assign bus.p0_rvalid = rvalid_r[PORT_CORE];
    assign bus.p1_rvalid = rvalid_r[PORT_AUX];
    assign bus.p0_rdata  = bus.mem_rdata;
    assign bus.p1_rdata  = bus.mem_rdata;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_r;

    // Saturating count of IDLE cycles in which both ports compete
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_r <= 16'h0000;
        end else if ((state_r == IDLE) && bus.p0_req && bus.p1_req && (conflict_r != 16'hFFFF)) begin
            conflict_r <= conflict_r + 16'h0001;
        end else begin
            conflict_r <= conflict_r;
        end
    end

    assign bus.conflict_count = conflict_r;
`else
    assign bus.conflict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two instances (read latency 1 and 3), each with a memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [16:0] exp_rd_q[$];
    int          exp_port_q[$];

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic [DW-1:0] mem1 [0:65535];
    logic [DW-1:0] mem3 [0:65535];
    logic [DW-1:0] pipe1;
    logic [DW-1:0] pipe3 [0:2];

    // Memory models: contents preloaded during reset, reads return after the configured latency
    always @(posedge clk) begin
        if (rst) begin
            mem1[16'h3C8C] <= 16'h1234;
            mem1[16'h0200] <= 16'hA0A0;
            mem1[16'h0300] <= 16'hB1B1;
            mem1[16'h0010] <= 16'h5555;
            mem3[16'h0020] <= 16'h7777;
        end else begin
            if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr[15:0]] <= bus1.mem_wdata;
            if (bus3.mem_en && bus3.mem_we) mem3[bus3.mem_addr[15:0]] <= bus3.mem_wdata;
        end
        pipe1    <= (bus1.mem_en && !bus1.mem_we) ? mem1[bus1.mem_addr[15:0]] : 16'hDEAD;
        pipe3[0] <= (bus3.mem_en && !bus3.mem_we) ? mem3[bus3.mem_addr[15:0]] : 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign bus1.mem_rdata = pipe1;
    assign bus3.mem_rdata = pipe3[2];

    task automatic idle_inputs();
        bus1.p0_req = 1'b0; bus1.p0_we = 1'b0; bus1.p0_addr = 24'h0; bus1.p0_wdata = 16'h0;
        bus1.p1_req = 1'b0; bus1.p1_we = 1'b0; bus1.p1_addr = 24'h0; bus1.p1_wdata = 16'h0;
        bus3.p0_req = 1'b0; bus3.p0_we = 1'b0; bus3.p0_addr = 24'h0; bus3.p0_wdata = 16'h0;
        bus3.p1_req = 1'b0; bus3.p1_we = 1'b0; bus3.p1_addr = 24'h0; bus3.p1_wdata = 16'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus1.p0_ack, bus1.p1_ack, bus1.p0_rvalid, bus1.p1_rvalid, bus1.mem_en, bus1.mem_we} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl1: got %b want 000000", {bus1.p0_ack, bus1.p1_ack, bus1.p0_rvalid, bus1.p1_rvalid, bus1.mem_en, bus1.mem_we});
            end
            checks++;
            if ({bus3.p0_ack, bus3.p1_ack, bus3.p0_rvalid, bus3.p1_rvalid, bus3.mem_en, bus3.mem_we} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl3: got %b want 000000", {bus3.p0_ack, bus3.p1_ack, bus3.p0_rvalid, bus3.p1_rvalid, bus3.mem_en, bus3.mem_we});
            end
            checks++;
            if (bus1.mem_addr !== 24'h0 || bus1.mem_wdata !== 16'h0) begin
                errors++;
                $display("FAIL reset_bus: addr %h wdata %h want 0 0", bus1.mem_addr, bus1.mem_wdata);
            end
            checks++;
            if (bus1.conflict_count !== 16'h0) begin
                errors++;
                $display("FAIL reset_conflict: got %h want 0000", bus1.conflict_count);
            end
        end
    endtask

    task automatic test_p0_read();
        bit got_rv = 1'b0;
        logic [16:0] exp;
        exp_rd_q.push_back({1'b0, 16'h1234});
        bus1.p0_req = 1'b1; bus1.p0_we = 1'b0; bus1.p0_addr = 24'h003C8C; bus1.p0_wdata = 16'h0;
        for (int k = 1; k <= 8 && !got_rv; k++) begin
            @(negedge clk);
            checks++;
            if (bus1.p1_ack !== 1'b0 || bus1.p1_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL p0rd_p1_quiet: ack %b rvalid %b want 0 0", bus1.p1_ack, bus1.p1_rvalid);
            end
            if (bus1.p0_ack) begin
                checks++;
                if (k !== 1) begin errors++; $display("FAIL p0rd_ack_cycle: got %0d want 1", k); end
                bus1.p0_req = 1'b0;
            end
            if (bus1.p0_rvalid) begin
                got_rv = 1'b1;
                checks++;
                if (k !== 2) begin errors++; $display("FAIL p0rd_rvalid_cycle: got %0d want 2", k); end
                if (exp_rd_q.size() != 0) begin
                    exp = exp_rd_q.pop_front();
                    checks++;
                    if ({1'b0, bus1.p0_rdata} !== exp) begin
                        errors++;
                        $display("FAIL p0rd_data: got %h want %h", bus1.p0_rdata, exp[15:0]);
                    end
                end
            end
        end
        checks++;
        if (!got_rv) begin errors++; $display("FAIL p0rd_timeout: got no rvalid want rvalid"); end
        exp_rd_q.delete();
        bus1.p0_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_p1_write();
        bus1.p1_req = 1'b1; bus1.p1_we = 1'b1; bus1.p1_addr = 24'h000100; bus1.p1_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({bus1.mem_en, bus1.mem_we, bus1.p1_ack, bus1.p0_ack} !== 4'b1110) begin
            errors++;
            $display("FAIL p1wr_strobe: got %b want 1110", {bus1.mem_en, bus1.mem_we, bus1.p1_ack, bus1.p0_ack});
        end
        checks++;
        if (bus1.mem_addr !== 24'h000100) begin errors++; $display("FAIL p1wr_addr: got %h want 000100", bus1.mem_addr); end
        checks++;
        if (bus1.mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL p1wr_data: got %h want BEEF", bus1.mem_wdata); end
        bus1.p1_req = 1'b0; bus1.p1_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus1.mem_en, bus1.mem_we, bus1.p1_ack, bus1.p1_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL p1wr_release: got %b want 0000", {bus1.mem_en, bus1.mem_we, bus1.p1_ack, bus1.p1_rvalid});
        end
    endtask

    task automatic test_round_robin(input int n);
        int acks = 0;
        int exp_p;
        logic [16:0] exp;
        logic [16:0] got;
        apply_reset();
        for (int i = 0; i < n; i++) begin
            exp_port_q.push_back(i % 2);
            exp_rd_q.push_back((i % 2 == 0) ? {1'b0, 16'hA0A0} : {1'b1, 16'hB1B1});
        end
        bus1.p0_req = 1'b1; bus1.p0_we = 1'b0; bus1.p0_addr = 24'h000200;
        bus1.p1_req = 1'b1; bus1.p1_we = 1'b0; bus1.p1_addr = 24'h000300;
        for (int c = 0; c < 8 * n && exp_rd_q.size() != 0; c++) begin
            @(negedge clk);
            if (bus1.p0_ack || bus1.p1_ack) begin
                checks++;
                if (bus1.p0_ack && bus1.p1_ack) begin
                    errors++; $display("FAIL rr_double_ack: got 11 want one-hot");
                end else if (exp_port_q.size() == 0) begin
                    errors++; $display("FAIL rr_extra_ack: got port %0d want none", bus1.p1_ack);
                end else begin
                    exp_p = exp_port_q.pop_front();
                    if (int'(bus1.p1_ack) !== exp_p) begin
                        errors++; $display("FAIL rr_order: grant %0d got port %0d want %0d", acks, bus1.p1_ack, exp_p);
                    end
                end
                acks++;
                if (acks == n) begin bus1.p0_req = 1'b0; bus1.p1_req = 1'b0; end
            end
            if (bus1.p0_rvalid || bus1.p1_rvalid) begin
                got = {bus1.p1_rvalid, bus1.p1_rvalid ? bus1.p1_rdata : bus1.p0_rdata};
                exp = exp_rd_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL rr_rdata: got %h want %h", got, exp); end
            end
        end
        checks++;
        if (exp_rd_q.size() != 0) begin errors++; $display("FAIL rr_timeout: %0d reads outstanding want 0", exp_rd_q.size()); end
        exp_rd_q.delete();
        exp_port_q.delete();
        bus1.p0_req = 1'b0; bus1.p1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_same_addr();
        int exp_p;
        logic [16:0] exp;
        apply_reset();
        exp_port_q.push_back(0);
        exp_port_q.push_back(1);
        exp_rd_q.push_back({1'b1, 16'h00AA});
        bus1.p0_req = 1'b1; bus1.p0_we = 1'b1; bus1.p0_addr = 24'h000010; bus1.p0_wdata = 16'h00AA;
        bus1.p1_req = 1'b1; bus1.p1_we = 1'b0; bus1.p1_addr = 24'h000010; bus1.p1_wdata = 16'h0;
        for (int c = 0; c < 20 && exp_rd_q.size() != 0; c++) begin
            @(negedge clk);
            if (bus1.p0_ack || bus1.p1_ack) begin
                checks++;
                if (exp_port_q.size() == 0) begin
                    errors++; $display("FAIL raw_extra_ack: got port %0d want none", bus1.p1_ack);
                end else begin
                    exp_p = exp_port_q.pop_front();
                    if (int'(bus1.p1_ack) !== exp_p) begin
                        errors++; $display("FAIL raw_order: got port %0d want %0d", bus1.p1_ack, exp_p);
                    end
                end
                if (bus1.p0_ack) bus1.p0_req = 1'b0;
                if (bus1.p1_ack) bus1.p1_req = 1'b0;
            end
            if (bus1.p0_rvalid || bus1.p1_rvalid) begin
                exp = exp_rd_q.pop_front();
                checks++;
                if ({bus1.p1_rvalid, bus1.p1_rdata} !== exp) begin
                    errors++; $display("FAIL raw_rdata: got %b/%h want %h", bus1.p1_rvalid, bus1.p1_rdata, exp);
                end
            end
        end
        checks++;
        if (exp_rd_q.size() != 0) begin errors++; $display("FAIL raw_timeout: got no rvalid want rvalid"); end
        exp_rd_q.delete();
        exp_port_q.delete();
        bus1.p0_req = 1'b0; bus1.p1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        bit got_rv = 1'b0;
        logic [16:0] exp;
        apply_reset();
        bus3.p0_req = 1'b1; bus3.p0_we = 1'b0; bus3.p0_addr = 24'h000020; bus3.p0_wdata = 16'hC3C3;
        @(negedge clk);
        checks++;
        if (bus3.p0_ack !== 1'b1) begin errors++; $display("FAIL rstw_ack: got %b want 1", bus3.p0_ack); end
        bus3.p0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus3.p0_rvalid !== 1'b0) begin errors++; $display("FAIL rstw_early_rvalid: got %b want 0", bus3.p0_rvalid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus3.p0_ack, bus3.p0_rvalid, bus3.mem_en, bus3.mem_we} !== 4'b0000) begin
            errors++; $display("FAIL rstw_ctrl: got %b want 0000", {bus3.p0_ack, bus3.p0_rvalid, bus3.mem_en, bus3.mem_we});
        end
        checks++;
        if (bus3.mem_addr !== 24'h0 || bus3.mem_wdata !== 16'h0) begin
            errors++; $display("FAIL rstw_bus: addr %h wdata %h want 0 0", bus3.mem_addr, bus3.mem_wdata);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus3.p0_rvalid !== 1'b0) begin errors++; $display("FAIL rstw_stale_rvalid: got 1 want 0"); end
        end
        exp_rd_q.push_back({1'b0, 16'h7777});
        bus3.p0_req = 1'b1; bus3.p0_addr = 24'h000020;
        for (int k = 1; k <= 10 && !got_rv; k++) begin
            @(negedge clk);
            if (bus3.p0_ack) begin
                checks++;
                if (k !== 1) begin errors++; $display("FAIL lat3_ack_cycle: got %0d want 1", k); end
                bus3.p0_req = 1'b0;
            end
            if (bus3.p0_rvalid) begin
                got_rv = 1'b1;
                exp = exp_rd_q.pop_front();
                checks++;
                if (k !== 4) begin errors++; $display("FAIL lat3_rvalid_cycle: got %0d want 4", k); end
                checks++;
                if ({1'b0, bus3.p0_rdata} !== exp) begin errors++; $display("FAIL lat3_data: got %h want %h", bus3.p0_rdata, exp[15:0]); end
            end
        end
        checks++;
        if (!got_rv) begin errors++; $display("FAIL lat3_timeout: got no rvalid want rvalid"); end
        exp_rd_q.delete();
        bus3.p0_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stats();
        logic [15:0] exp_cnt;
`ifdef MEM_ARB_STATS_EN
        exp_cnt = 16'd10;
`else
        exp_cnt = 16'd0;
`endif
        test_round_robin(10);
        repeat (3) @(negedge clk);
        checks++;
        if (bus1.conflict_count !== exp_cnt) begin
            errors++; $display("FAIL stats_count: got %0d want %0d", bus1.conflict_count, exp_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_p0_read();
        test_p1_write();
        test_round_robin(4);
        test_same_addr();
        test_reset_in_wait();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
